// File: rtl/thread_mmu.sv
// thread_mmu: per-thread I/D region check plus round-robin cache-fill engine; done follows a request by >=4 cycles (2 if faulted).
// Fill requests are level and held until done; ready stalls ISSUE, tx_done ends WAIT. MMU_RELOCATE_EN selects base-relative addressing.
module thread_mmu #(
   parameter int NUM_TRD = 8,
   parameter int TRD_W   = 3,
   parameter int AW      = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    i_addr,
   input  logic [TRD_W-1:0] i_trd,
   input  logic             i_rd,
   input  logic [AW-1:0]    d_addr,
   input  logic [TRD_W-1:0] d_trd,
   input  logic             d_rd,
   input  logic             d_wr,
   output logic             i_segfault,
   output logic             d_segfault,
   input  logic             i_fill_req,
   input  logic             d_fill_req,
   input  logic             d_fill_wr,
   output logic             i_fill_done,
   output logic             d_fill_done,
   output logic             fill_err,
   input  logic             cfg_we,
   input  logic             cfg_side,
   input  logic [TRD_W-1:0] cfg_trd,
   input  logic [AW-1:0]    cfg_base,
   input  logic [AW-1:0]    cfg_limit,
   input  logic             ready,
   input  logic             tx_done,
   output logic [1:0]       mem_op,
   output logic [63:0]      cpu_addr
);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

   state_t        r_state, w_nxt;
   logic [AW-1:0] r_i_base [NUM_TRD];
   logic [AW-1:0] r_i_lim  [NUM_TRD];
   logic [AW-1:0] r_d_base [NUM_TRD];
   logic [AW-1:0] r_d_lim  [NUM_TRD];
   logic          r_side, r_last_d, r_err;
   logic          r_i_done, r_d_done, r_fill_err;
   logic [1:0]    r_op;
   logic [AW-1:0] r_addr;
   logic [AW:0]   w_i_chk, w_d_chk;
   logic          w_i_pend, w_d_pend, w_grant, w_gnt_d, w_sel_valid;
   logic [AW-1:0] w_sel_phys;
   logic [1:0]    w_mem_op;

   // Returns {valid, physical address} for one table entry.
   function automatic logic [AW:0] f_xlate(input logic [AW-1:0] base,
                                           input logic [AW-1:0] limit,
                                           input logic [AW-1:0] addr);
`ifdef MMU_RELOCATE_EN
      logic [AW:0] sum;
      sum = {1'b0, base} + {1'b0, addr};
      return {(~sum[AW]) && (sum[AW-1:0] <= limit), sum[AW-1:0]};
`else
      return {(base <= addr) && (addr <= limit), addr};
`endif
   endfunction

   assign w_i_chk    = f_xlate(r_i_base[i_trd], r_i_lim[i_trd], i_addr);
   assign w_d_chk    = f_xlate(r_d_base[d_trd], r_d_lim[d_trd], d_addr);
   assign i_segfault = i_rd & ~w_i_chk[AW];
   assign d_segfault = (d_rd | d_wr) & ~w_d_chk[AW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < NUM_TRD; t++) begin
            r_i_base[t] <= '1;
            r_i_lim[t]  <= '0;
            r_d_base[t] <= '1;
            r_d_lim[t]  <= '0;
         end
         r_i_base[0] <= AW'(32'h0001_0000);
         r_i_lim[0]  <= AW'(32'h0001_01FF);
         r_d_base[0] <= AW'(32'h0001_0200);
         r_d_lim[0]  <= AW'(32'h0001_02FF);
      end else if (cfg_we) begin
         if (cfg_side) begin
            r_d_base[cfg_trd] <= cfg_base;
            r_d_lim[cfg_trd]  <= cfg_limit;
         end else begin
            r_i_base[cfg_trd] <= cfg_base;
            r_i_lim[cfg_trd]  <= cfg_limit;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nxt;
   end

   // A side whose done is pulsing this cycle is masked so it cannot be re-granted.
   always_comb begin
      w_nxt       = r_state;
      w_grant     = 1'b0;
      w_gnt_d     = 1'b0;
      w_mem_op    = 2'b00;
      w_i_pend    = i_fill_req & ~r_i_done;
      w_d_pend    = d_fill_req & ~r_d_done;
      w_sel_valid = 1'b0;
      w_sel_phys  = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_i_pend || w_d_pend) begin
               w_grant     = 1'b1;
               w_gnt_d     = w_d_pend && (!w_i_pend || !r_last_d);
               w_sel_valid = w_gnt_d ? w_d_chk[AW] : w_i_chk[AW];
               w_sel_phys  = w_gnt_d ? w_d_chk[AW-1:0] : w_i_chk[AW-1:0];
               w_nxt       = w_sel_valid ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: begin
            w_mem_op = r_op;
            if (ready) w_nxt = ST_WAIT;
         end
         ST_WAIT: if (tx_done) w_nxt = ST_DONE;
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_side     <= 1'b0;
         r_last_d   <= 1'b0;
         r_err      <= 1'b0;
         r_op       <= 2'b00;
         r_addr     <= '0;
         r_i_done   <= 1'b0;
         r_d_done   <= 1'b0;
         r_fill_err <= 1'b0;
      end else begin
         r_i_done   <= (r_state == ST_DONE) && !r_side;
         r_d_done   <= (r_state == ST_DONE) && r_side;
         r_fill_err <= (r_state == ST_DONE) && r_err;
         if (w_grant) begin
            r_side   <= w_gnt_d;
            r_last_d <= w_gnt_d;
            r_op     <= (w_gnt_d && d_fill_wr) ? 2'b11 : 2'b01;
            r_err    <= !w_sel_valid;
            if (w_sel_valid) r_addr <= w_sel_phys;
         end
      end
   end

   assign mem_op      = w_mem_op;
   assign cpu_addr    = {{(64-AW){1'b0}}, r_addr};
   assign i_fill_done = r_i_done;
   assign d_fill_done = r_d_done;
   assign fill_err    = r_fill_err;

endmodule

// File: tb/tb_thread_mmu.sv
// Directed bench for thread_mmu: region checks, config timing, fill FSM latency, arbitration, faults, async reset.
module tb_thread_mmu;
   localparam int AW = 32, TRD_W = 3, NUM_TRD = 8;

`ifdef MMU_RELOCATE_EN
   localparam logic [31:0] I_OK = 32'h1FF,   I_BAD = 32'h200,   FILL_A = 32'h10;
   localparam logic [31:0] NEW_A = 32'h10,   D0_A = 32'h40;
   localparam logic [31:0] R_OK = 32'h40,    R_BAD = 32'h100;
`else
   localparam logic [31:0] I_OK = 32'h101FF, I_BAD = 32'h10200, FILL_A = 32'h10010;
   localparam logic [31:0] NEW_A = 32'h5010, D0_A = 32'h10240;
   localparam logic [31:0] R_OK = 32'h30040, R_BAD = 32'h30100;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic [AW-1:0]    i_addr, d_addr, cfg_base, cfg_limit;
   logic [TRD_W-1:0] i_trd, d_trd, cfg_trd;
   logic             i_rd, d_rd, d_wr, i_fill_req, d_fill_req, d_fill_wr;
   logic             cfg_we, cfg_side, ready, tx_done;
   logic             i_segfault, d_segfault, i_fill_done, d_fill_done, fill_err;
   logic [1:0]       mem_op;
   logic [63:0]      cpu_addr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   thread_mmu #(.NUM_TRD(NUM_TRD), .TRD_W(TRD_W), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_addr(i_addr), .i_trd(i_trd), .i_rd(i_rd),
      .d_addr(d_addr), .d_trd(d_trd), .d_rd(d_rd), .d_wr(d_wr),
      .i_segfault(i_segfault), .d_segfault(d_segfault),
      .i_fill_req(i_fill_req), .d_fill_req(d_fill_req), .d_fill_wr(d_fill_wr),
      .i_fill_done(i_fill_done), .d_fill_done(d_fill_done), .fill_err(fill_err),
      .cfg_we(cfg_we), .cfg_side(cfg_side), .cfg_trd(cfg_trd),
      .cfg_base(cfg_base), .cfg_limit(cfg_limit),
      .ready(ready), .tx_done(tx_done), .mem_op(mem_op), .cpu_addr(cpu_addr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      i_fill_req = 0; d_fill_req = 0; d_fill_wr = 0; ready = 0; tx_done = 0;
      i_rd = 0; d_rd = 0; d_wr = 0; cfg_we = 0;
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      i_addr = 0; d_addr = 0; i_trd = 0; d_trd = 0; cfg_side = 0; cfg_trd = 0;
      cfg_base = 0; cfg_limit = 0;
      i_fill_req = 0; d_fill_req = 0; d_fill_wr = 0; ready = 0; tx_done = 0;
      i_rd = 0; d_rd = 0; d_wr = 0; cfg_we = 0;
      rst_n = 0;
      tick(); tick();
      checks++; if (mem_op !== 2'b00) begin errors++; $display("FAIL reset_mem_op: got %b want 00", mem_op); end
      checks++; if (cpu_addr !== 64'h0) begin errors++; $display("FAIL reset_cpu_addr: got %h want 0", cpu_addr); end
      checks++; if ({i_fill_done, d_fill_done, fill_err} !== 3'b000) begin
         errors++; $display("FAIL reset_done_err: got %b want 000", {i_fill_done, d_fill_done, fill_err}); end
      rst_n = 1;
      tick();
   endtask

   task automatic test_segfault();
      i_rd = 1; i_trd = 0; i_addr = I_OK; #1;
      checks++; if (i_segfault !== 1'b0) begin errors++; $display("FAIL seg_i_limit: got %b want 0", i_segfault); end
      i_addr = I_BAD; #1;
      checks++; if (i_segfault !== 1'b1) begin errors++; $display("FAIL seg_i_above: got %b want 1", i_segfault); end
      i_rd = 0; #1;
      checks++; if (i_segfault !== 1'b0) begin errors++; $display("FAIL seg_i_no_rd: got %b want 0", i_segfault); end
      d_wr = 1; d_trd = 3; d_addr = D0_A; #1;
      checks++; if (d_segfault !== 1'b1) begin errors++; $display("FAIL seg_d_trd3: got %b want 1", d_segfault); end
      d_wr = 0; d_rd = 1; d_trd = 0; #1;
      checks++; if (d_segfault !== 1'b0) begin errors++; $display("FAIL seg_d_trd0: got %b want 0", d_segfault); end
      d_rd = 0; d_trd = 3; #1;
      checks++; if (d_segfault !== 1'b0) begin errors++; $display("FAIL seg_d_idle: got %b want 0", d_segfault); end
   endtask

   task automatic test_cfg_timing();
      i_rd = 1; i_trd = 1; i_addr = NEW_A;
      cfg_we = 1; cfg_side = 0; cfg_trd = 1; cfg_base = 32'h5000; cfg_limit = 32'h50FF; #1;
      checks++; if (i_segfault !== 1'b1) begin errors++; $display("FAIL cfg_old_entry: got %b want 1", i_segfault); end
      tick();
      cfg_we = 0; #1;
      checks++; if (i_segfault !== 1'b0) begin errors++; $display("FAIL cfg_new_entry: got %b want 0", i_segfault); end
      i_rd = 0; i_trd = 0;
   endtask

   task automatic test_i_fill();
      int cnt01, ndone, done_cyc, stray;
      cnt01 = 0; ndone = 0; done_cyc = -1; stray = 0;
      ready = 0; tx_done = 0; i_trd = 0; i_addr = FILL_A; i_fill_req = 1;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         if (mem_op === 2'b01) cnt01++;
         if (cyc == 1) begin
            checks++; if (cpu_addr !== 64'h10010) begin errors++; $display("FAIL ifill_addr: got %h want 10010", cpu_addr); end
         end
         if (cyc == 8) begin
            checks++; if (mem_op !== 2'b00) begin errors++; $display("FAIL ifill_wait_op: got %b want 00", mem_op); end
            checks++; if (cpu_addr !== 64'h10010) begin errors++; $display("FAIL ifill_wait_addr: got %h want 10010", cpu_addr); end
         end
         if (i_fill_done === 1'b1) begin ndone++; done_cyc = cyc; i_fill_req = 0; end
         if (d_fill_done !== 1'b0 || fill_err !== 1'b0) stray++;
         if (cyc == 2) tx_done = 1;
         if (cyc == 3) tx_done = 0;
         if (cyc == 6) ready = 1;
         if (cyc == 9) tx_done = 1;
      end
      checks++; if (cnt01 != 6) begin errors++; $display("FAIL ifill_read_cycles: got %0d want 6", cnt01); end
      checks++; if (done_cyc != 11) begin errors++; $display("FAIL ifill_done_cycle: got %0d want 11", done_cyc); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL ifill_done_count: got %0d want 1", ndone); end
      checks++; if (stray != 0) begin errors++; $display("FAIL ifill_stray: got %0d want 0", stray); end
      ready = 0; tx_done = 0;
   endtask

   task automatic test_arb();
      logic [1:0] op_at [13];
      int icyc, dcyc, ni, nd, nerr;
      icyc = -1; dcyc = -1; ni = 0; nd = 0; nerr = 0;
      apply_reset();
      ready = 1; tx_done = 1;
      i_trd = 0; i_addr = FILL_A; d_trd = 0; d_addr = D0_A; d_fill_wr = 1;
      i_fill_req = 1; d_fill_req = 1;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         tick();
         op_at[cyc] = mem_op;
         if (cyc == 1) begin
            checks++; if (cpu_addr !== 64'h10240) begin errors++; $display("FAIL arb_d_addr: got %h want 10240", cpu_addr); end
         end
         if (cyc == 5) begin
            checks++; if (cpu_addr !== 64'h10010) begin errors++; $display("FAIL arb_i_addr: got %h want 10010", cpu_addr); end
         end
         if (fill_err === 1'b1) nerr++;
         if (i_fill_done === 1'b1) begin ni++; icyc = cyc; i_fill_req = 0; end
         if (d_fill_done === 1'b1) begin nd++; dcyc = cyc; d_fill_req = 0; end
      end
      checks++; if (op_at[1] !== 2'b11) begin errors++; $display("FAIL arb_first_op: got %b want 11", op_at[1]); end
      checks++; if (op_at[5] !== 2'b01) begin errors++; $display("FAIL arb_second_op: got %b want 01", op_at[5]); end
      checks++; if (dcyc != 4 || nd != 1) begin errors++; $display("FAIL arb_d_done: got cyc %0d n %0d want cyc 4 n 1", dcyc, nd); end
      checks++; if (icyc != 8 || ni != 1) begin errors++; $display("FAIL arb_i_done: got cyc %0d n %0d want cyc 8 n 1", icyc, ni); end
      checks++; if (nerr != 0) begin errors++; $display("FAIL arb_err: got %0d want 0", nerr); end
      d_fill_wr = 0;
   endtask

   task automatic test_fault();
      int busy, dcyc, nerr, ni;
      busy = 0; dcyc = -1; nerr = 0; ni = 0;
      ready = 1; tx_done = 1;
      d_trd = 0; d_addr = 32'h20000; d_fill_wr = 1; d_fill_req = 1;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         tick();
         if (mem_op !== 2'b00) busy++;
         if (fill_err === 1'b1) nerr++;
         if (i_fill_done === 1'b1) ni++;
         if (d_fill_done === 1'b1) begin
            dcyc = cyc;
            checks++; if (fill_err !== 1'b1) begin errors++; $display("FAIL fault_err_with_done: got %b want 1", fill_err); end
            d_fill_req = 0;
         end
      end
      checks++; if (busy != 0) begin errors++; $display("FAIL fault_mem_op: got %0d busy cycles want 0", busy); end
      checks++; if (dcyc != 2) begin errors++; $display("FAIL fault_done_cycle: got %0d want 2", dcyc); end
      checks++; if (nerr != 1 || ni != 0) begin errors++; $display("FAIL fault_counts: got err %0d idone %0d want 1 0", nerr, ni); end
      ready = 0; tx_done = 0; d_fill_wr = 0;
   endtask

   task automatic test_reset_wait();
      int seen;
      seen = 0;
      ready = 1; tx_done = 0; i_trd = 0; i_addr = FILL_A; i_fill_req = 1;
      tick();
      checks++; if (mem_op !== 2'b01) begin errors++; $display("FAIL rstw_issue: got %b want 01", mem_op); end
      tick();
      checks++; if (cpu_addr !== 64'h10010) begin errors++; $display("FAIL rstw_wait_addr: got %h want 10010", cpu_addr); end
      #2 rst_n = 0;
      #1;
      checks++; if (cpu_addr !== 64'h0 || mem_op !== 2'b00) begin
         errors++; $display("FAIL rstw_async: got addr %h op %b want 0 00", cpu_addr, mem_op); end
      #1 rst_n = 1;
      tick();
      checks++; if (mem_op !== 2'b01 || cpu_addr !== 64'h10010) begin
         errors++; $display("FAIL rstw_regrant: got op %b addr %h want 01 10010", mem_op, cpu_addr); end
      tx_done = 1;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         if (i_fill_done === 1'b1) begin seen++; i_fill_req = 0; end
      end
      checks++; if (seen != 1) begin errors++; $display("FAIL rstw_done: got %0d pulses want 1", seen); end
      ready = 0; tx_done = 0;
   endtask

   task automatic test_reloc_cfg();
      int seen, nerr, dcyc;
      cfg_we = 1; cfg_side = 1; cfg_trd = 2; cfg_base = 32'h30000; cfg_limit = 32'h300FF;
      tick();
      cfg_we = 0;
      d_rd = 1; d_trd = 2; d_addr = R_OK; #1;
      checks++; if (d_segfault !== 1'b0) begin errors++; $display("FAIL reloc_seg_ok: got %b want 0", d_segfault); end
      d_addr = R_BAD; #1;
      checks++; if (d_segfault !== 1'b1) begin errors++; $display("FAIL reloc_seg_bad: got %b want 1", d_segfault); end
      d_rd = 0;
      d_addr = R_OK; d_fill_wr = 0; d_fill_req = 1; ready = 0; tx_done = 0;
      tick();
      checks++; if (mem_op !== 2'b01 || cpu_addr !== 64'h30040) begin
         errors++; $display("FAIL reloc_issue: got op %b addr %h want 01 30040", mem_op, cpu_addr); end
      cfg_we = 1; cfg_base = 32'h50000; cfg_limit = 32'h500FF;
      tick();
      cfg_we = 0;
      checks++; if (cpu_addr !== 64'h30040) begin errors++; $display("FAIL reloc_cfg_hold: got %h want 30040", cpu_addr); end
      ready = 1; tx_done = 1;
      seen = 0; nerr = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         tick();
         if (d_fill_done === 1'b1) begin seen++; d_fill_req = 0; end
         if (fill_err === 1'b1) nerr++;
      end
      checks++; if (seen != 1 || nerr != 0) begin errors++; $display("FAIL reloc_ok_done: got %0d pulses %0d err want 1 0", seen, nerr); end
      cfg_we = 1; cfg_base = 32'h30000; cfg_limit = 32'h300FF;
      tick();
      cfg_we = 0;
      d_addr = R_BAD; d_fill_req = 1;
      dcyc = -1; nerr = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         tick();
         if (fill_err === 1'b1) nerr++;
         if (d_fill_done === 1'b1) begin dcyc = cyc; d_fill_req = 0; end
      end
      checks++; if (dcyc != 2 || nerr != 1) begin errors++; $display("FAIL reloc_bad_fill: got cyc %0d err %0d want 2 1", dcyc, nerr); end
      ready = 0; tx_done = 0;
   endtask

   initial begin
      test_reset();
      test_segfault();
      test_cfg_timing();
      test_i_fill();
      test_arb();
      test_fault();
      test_reset_wait();
      test_reloc_cfg();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
